load_align_unit: RTL
====================

Name: load_align_unit

Overview:
- Parametrised successor to the memory-stage load extractor. Accepts one load at a time from the memory stage.
- Issues one or two word-aligned data-bus reads. A load that crosses a word boundary is split across two beats.
- Merges and sign/zero-extends the selected bytes, then returns a registered result under a valid/ready handshake.
- Sits between the memory-stage control and the dbus port. Misaligned-load handling is selected by a mode parameter.

Parameters:
- DATA_W, 64, bus/register width in bits; legal values 32 or 64. BYTES = DATA_W/8, OFF_W = log2(BYTES).
- ADDR_W, 64, load address width.
- ALLOW_SPLIT, 1, 1 = misaligned loads are serviced (two beats if spanning); 0 = any misaligned load raises an error with no bus access.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  load request valid.
- in_ready  out  1  unit can accept a request.
- in_addr  in  ADDR_W  byte address of the load.
- in_size  in  2  log2 of byte count: 0=1B, 1=2B, 2=4B, 3=8B.
- in_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- dreq_valid  out  1  bus read request.
- dreq_addr  out  ADDR_W  word-aligned bus address (low OFF_W bits are 0).
- dresp_data_ok  in  1  bus returns data this cycle; also completes the request.
- dresp_data  in  DATA_W  bus read data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- out_data  out  DATA_W  extended load result.
- out_err  out  1  misaligned/illegal load; out_data is 0 when set.

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP.
- Reset (asynchronous, active-low): state=IDLE. All outputs 0 except in_ready=1. Internal beat registers are cleared.
- in_ready=1 only in IDLE. A request is accepted on a clk edge with in_valid&&in_ready. addr, size and unsigned are captured at that edge.
- On accept, compute:
  - off = addr[OFF_W-1:0]
  - nb = 1<<size
  - mis = (off % nb) != 0
  - span = (off + nb) > BYTES
- Illegal request (size=3 with DATA_W=32), or mis with ALLOW_SPLIT=0:
  - go to RESP with out_err=1 and out_data=0.
  - No dreq is issued.
- Otherwise go to BEAT0 with dreq_addr = addr with low OFF_W bits cleared.
- BEAT0: dreq_valid=1, dreq_addr held stable until dresp_data_ok. On dresp_data_ok, capture beat0. Then:
  - if span, go to BEAT1 with dreq_addr += BYTES (ADDR_W wrap permitted);
  - if not span, go to RESP.
- BEAT1: same protocol as BEAT0. On dresp_data_ok, capture beat1 and go to RESP.
- dreq_valid drops in the cycle after the final dresp_data_ok. dreq_valid is never asserted in IDLE or RESP.
- Merge: form the 2*DATA_W value {beat1, beat0}; beat1 = 0 if not span. Shift it right by off*8 and keep the low nb bytes.
- Extension: fill bits above nb*8 with 0 if unsigned, else with bit nb*8-1. Size equal to DATA_W passes through unchanged.
- Timing: out_data and out_err are registered on the edge that enters RESP. out_valid=1 throughout RESP.
- In RESP, outputs are held stable while out_ready=0. On out_ready, go to IDLE; out_valid=0 on the next cycle.
- No accept in the same cycle as the RESP handshake: minimum one IDLE cycle between loads.
- Latency with zero-wait bus (dresp_data_ok in the first request cycle):
  - 1-beat load: out_valid 2 cycles after accept.
  - 2-beat load: out_valid 3 cycles after accept.
- in_valid while busy is ignored; the request must be held by the upstream stage.
- Reset asserted mid-transaction (BEAT0/BEAT1/RESP): return to IDLE immediately and drop dreq_valid. Any outstanding bus response is discarded; the bus side must tolerate the abandoned request.
- dresp_data_ok in IDLE or RESP is ignored.

Test Plan:
- DATA_W=64, LB signed at 0x1007, beat0=0x8877665544332211 -> one dreq at 0x1000; out_data=0xFFFFFFFFFFFFFF88, out_err=0.
- LBU at 0x1003, same data -> out_data=0x0000000000000044. LHU at 0x1002 -> 0x0000000000004433.
- ALLOW_SPLIT=1, LW signed at 0x1006, beat0=0x8877665544332211, beat1 (0x1008)=0x00FFEEDDCCBBAA99:
  - dreq at 0x1000 then 0x1008;
  - out_data=0xFFFFFFFFAA998877.
  - Zero-wait bus gives out_valid 3 cycles after accept.
- ALLOW_SPLIT=0, LH at 0x1001 -> dreq_valid never asserted; out_err=1, out_data=0, out_valid 1 cycle after accept.
- LD at 0x2000 with bus wait of 4 cycles and out_ready low for 3 RESP cycles:
  - dreq_addr held at 0x2000 throughout the wait;
  - out_data=beat0 held stable while out_ready is low; in_ready stays 0 until the handshake.
- Reset pulsed low in BEAT1 of a spanning load -> dreq_valid=0 and in_ready=1 immediately; a later LW at 0x3000 completes normally.

Source files
------------

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two word-aligned bus reads per load.
// It then merges, extracts and sign/zero-extends the addressed bytes into a registered result.
module load_align_unit #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int ALLOW_SPLIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              span_q;
    logic [DATA_W-1:0] beat0_q;

    logic [OFF_W-1:0]  req_off;
    int                req_nb;
    logic              req_mis;
    logic              req_span;
    logic              req_illegal;
    logic              accept;
    logic              enter_resp;
    logic [DATA_W-1:0] merge_lo;
    logic [DATA_W-1:0] merge_hi;
    logic [DATA_W-1:0] load_result;

    // Shift the two-word window right to the addressed byte and keep the low word.
    function automatic logic [DATA_W-1:0] select_bytes(
        input logic [DATA_W-1:0] lo,
        input logic [DATA_W-1:0] hi,
        input logic [OFF_W-1:0]  off
    );
        logic [2*DATA_W-1:0] merged;
        merged = {hi, lo} >> {off, 3'b000};
        return merged[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] extend_bytes(
        input logic [DATA_W-1:0] v,
        input logic [1:0]        size,
        input logic              uns
    );
        int                nbits;
        logic [DATA_W-1:0] hi_mask;
        logic              fill;
        nbits = 8 << size;
        if (nbits >= DATA_W) begin
            return v;
        end
        hi_mask = {DATA_W{1'b1}} << nbits;
        fill    = !uns && v[nbits-1];
        return fill ? (v | hi_mask) : (v & ~hi_mask);
    endfunction

    always_comb begin
        req_off     = in_addr[OFF_W-1:0];
        req_nb      = 1 << in_size;
        req_mis     = (int'(req_off) & (req_nb - 1)) != 0;
        req_span    = (int'(req_off) + req_nb) > BYTES;
        req_illegal = (in_size == 2'd3 && DATA_W == 32) || (req_mis && ALLOW_SPLIT == 0);
    end

    assign in_ready   = (state == IDLE);
    assign dreq_valid = (state == BEAT0) || (state == BEAT1);
    assign out_valid  = (state == RESP);
    assign accept     = in_valid && in_ready;
    assign enter_resp = dresp_data_ok &&
                        ((state == BEAT0 && !span_q) || state == BEAT1);

    // A single-beat load has no upper word; in BEAT1 the live bus data is the upper word.
    assign merge_lo    = (state == BEAT1) ? beat0_q : dresp_data;
    assign merge_hi    = (state == BEAT1) ? dresp_data : '0;
    assign load_result = extend_bytes(select_bytes(merge_lo, merge_hi, off_q), size_q, uns_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = req_illegal ? RESP : BEAT0;
            BEAT0:   if (dresp_data_ok) state_nxt = span_q ? BEAT1 : RESP;
            BEAT1:   if (dresp_data_ok) state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            span_q    <= 1'b0;
            beat0_q   <= '0;
            dreq_addr <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (accept) begin
                off_q  <= req_off;
                size_q <= in_size;
                uns_q  <= in_unsigned;
                span_q <= req_span;
                if (req_illegal) begin
                    out_data <= '0;
                    out_err  <= 1'b1;
                end else begin
                    dreq_addr <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end
            end
            if (state == BEAT0 && dresp_data_ok) begin
                beat0_q <= dresp_data;
                if (span_q) begin
                    dreq_addr <= dreq_addr + ADDR_W'(BYTES);
                end
            end
            if (enter_resp) begin
                out_data <= load_result;
                out_err  <= 1'b0;
            end
        end
    end

endmodule
